adder_result_collector: RTL and testbench
=========================================

ADDER_RESULT_COLLECTOR -- requirements
Module: adder_result_collector

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 1000: samples per accumulation window, legal range 1..65535.
REQ-002 SHALL have parameter ACC_W, default 16: accumulator width, legal range 5..32.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port in_valid  input  1  upstream adder result present this cycle.
REQ-006 SHALL have port in_ready  output  1  collector accepts a sample this cycle.
REQ-007 SHALL have port Sum  input  3  adder sum bits.
REQ-008 SHALL have port Cout  input  1  adder carry-out.
REQ-009 SHALL have port clear  input  1  synchronous flush request.
REQ-010 SHALL have port out_valid  output  1  window result available.
REQ-011 SHALL have port out_ready  input  1  downstream takes the result.
REQ-012 SHALL have port out_acc  output  ACC_W  accumulated window total.
REQ-013 SHALL have port out_count  output  16  samples accepted in current window.
REQ-014 SHALL have port out_ovf  output  1  sticky saturation flag for current window.

Function
REQ-015 SHALL implement states IDLE, ACCUM, HOLD; encoding free.
REQ-016 SHALL drive in_ready combinationally as (state != HOLD) and not clear.
REQ-017 SHALL treat a sample as accepted on a rising edge where in_valid and in_ready are both 1.
REQ-018 SHALL form sample value as the 4-bit unsigned {Cout,Sum}, range 0..15, zero-extended to ACC_W.
REQ-019 SHALL, on accept, set acc <= acc + value and count <= count + 1 in the same edge.
REQ-020 SHALL saturate: if acc + value exceeds 2^ACC_W-1, acc <= all-ones and out_ovf <= 1; out_ovf stays 1 until window ends.
REQ-021 SHALL transition IDLE -> ACCUM on an accept that leaves count below MAX_COUNT.
REQ-022 SHALL transition IDLE or ACCUM -> HOLD on the accept making count equal MAX_COUNT (MAX_COUNT=1: IDLE -> HOLD directly).
REQ-023 SHALL register out_valid = (state == HOLD); out_valid rises the edge that accepts the final sample (zero extra latency).
REQ-024 SHALL hold out_acc, out_count, out_ovf stable while out_valid=1 and out_ready=0.
REQ-025 SHALL, in HOLD on an edge with out_ready=1, clear acc, count, out_ovf to 0 and go to IDLE; in_valid that cycle is not accepted.
REQ-026 SHALL treat out_ready outside HOLD as don't-care.
REQ-027 SHALL, on an edge with clear=1 in any state, zero acc, count, out_ovf and go to IDLE; clear overrides accept and out_ready; a held result is discarded.
REQ-028 SHALL drive out_acc and out_count continuously from the live registers, so partial totals are observable in ACCUM.

Reset
REQ-029 SHALL, while rst=0, immediately force state IDLE, acc 0, count 0, out_ovf 0, out_valid 0, independent of clk.
REQ-030 SHALL, on reset mid-window or in HOLD, discard all partial or held data with no result emitted.
REQ-031 SHALL resume normal accepts on the first rising edge after rst returns to 1.

Verification (MAX_COUNT=4, ACC_W=16 unless noted)
REQ-032 SHALL cover: reset, then samples {Cout,Sum}=3,7,15,0 back-to-back -> out_valid=1 after 4th edge, out_acc=25, out_count=4, out_ovf=0, in_ready=0.
REQ-033 SHALL cover: result held, out_ready=0 for 5 cycles with in_valid=1 -> outputs unchanged, no accepts; out_ready=1 -> next cycle out_valid=0, out_acc=0, in_ready=1.
REQ-034 SHALL cover: ACC_W=5, four samples of 15 -> out_acc=31, out_ovf=1 after 3rd sample and held through HOLD.
REQ-035 SHALL cover: two samples of 5, then clear=1 with in_valid=1 -> sample dropped, out_acc=0, out_count=0, state IDLE.
REQ-036 SHALL cover: rst=0 asserted between edges during ACCUM with out_acc=9 -> out_acc=0, out_count=0 without a clock edge.
REQ-037 SHALL cover: MAX_COUNT=1, single sample 6 -> out_valid=1 after one edge, out_acc=6, out_count=1.

Source files
------------

// File: rtl/adder_result_collector.sv
// Accumulates 4-bit adder results ({Cout,Sum}) over a window of MAX_COUNT
// samples with saturation; holds the window total until out_ready.
module adder_result_collector #(
  parameter int unsigned MAX_COUNT = 1000,
  parameter int unsigned ACC_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       Sum,
  input  logic             Cout,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_acc,
  output logic [15:0]      out_count,
  output logic             out_ovf
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    HOLD
  } state_t;

  localparam logic [16:0] MAXC = 17'(MAX_COUNT);

  state_t           state, state_d;
  logic [ACC_W-1:0] acc, acc_d;
  logic [15:0]      count, count_d;
  logic             ovf, ovf_d;
  logic [ACC_W:0]   sum_w;
  logic [16:0]      cnt_inc;
  logic             accept;

  assign in_ready = (state != HOLD) && !clear;
  assign accept   = in_valid && in_ready;

  // one spare bit catches the saturation carry
  assign sum_w   = {1'b0, acc} + (ACC_W+1)'({Cout, Sum});
  assign cnt_inc = {1'b0, count} + 17'd1;

  always_comb begin
    state_d = state;
    acc_d   = acc;
    count_d = count;
    ovf_d   = ovf;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      count_d = '0;
      ovf_d   = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            count_d = '0;
            ovf_d   = 1'b0;
          end
        end
        IDLE, ACCUM: begin
          if (accept) begin
            if (sum_w[ACC_W]) begin
              acc_d = '1;
              ovf_d = 1'b1;
            end else begin
              acc_d = sum_w[ACC_W-1:0];
            end
            count_d = cnt_inc[15:0];
            state_d = (cnt_inc == MAXC) ? HOLD : ACCUM;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      state     <= state_d;
      acc       <= acc_d;
      count     <= count_d;
      ovf       <= ovf_d;
      out_valid <= (state_d == HOLD);
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

endmodule

// File: tb/tb_adder_result_collector.sv
// Bench for adder_result_collector: three instances (4/16, 4/5, 1/16)
// share stimulus; directed tasks plus a randomized window model.
module tb_adder_result_collector;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic [2:0] Sum = '0;
  logic Cout = 1'b0;
  logic clear = 1'b0;
  logic out_ready = 1'b0;

  logic rdy0, rdy1, rdy2;
  logic vl0, vl1, vl2;
  logic ov0, ov1, ov2;
  logic [15:0] acc0, acc2;
  logic [4:0] acc1;
  logic [15:0] ct0, ct1, ct2;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  adder_result_collector #(.MAX_COUNT(4), .ACC_W(16)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0),
    .Sum(Sum), .Cout(Cout), .clear(clear), .out_valid(vl0),
    .out_ready(out_ready), .out_acc(acc0), .out_count(ct0),
    .out_ovf(ov0)
  );

  adder_result_collector #(.MAX_COUNT(4), .ACC_W(5)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1),
    .Sum(Sum), .Cout(Cout), .clear(clear), .out_valid(vl1),
    .out_ready(out_ready), .out_acc(acc1), .out_count(ct1),
    .out_ovf(ov1)
  );

  adder_result_collector #(.MAX_COUNT(1), .ACC_W(16)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2),
    .Sum(Sum), .Cout(Cout), .clear(clear), .out_valid(vl2),
    .out_ready(out_ready), .out_acc(acc2), .out_count(ct2),
    .out_ovf(ov2)
  );

  task automatic drive(input logic v, input logic [3:0] val,
                       input logic clr, input logic ordy);
    @(negedge clk);
    in_valid = v;
    {Cout, Sum} = val;
    clear = clr;
    out_ready = ordy;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 0; {Cout, Sum} = 0; clear = 0; out_ready = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 0;
    #1;
    n_tests++;
    if (vl0 !== 0 || acc0 !== 0 || ct0 !== 0 || ov0 !== 0) begin
      n_fail++;
      $display("FAIL reset_outs: got v=%0d a=%0d c=%0d o=%0d want 0 0 0 0",
               vl0, acc0, ct0, ov0);
    end
    n_tests++;
    if (rdy0 !== 1) begin
      n_fail++;
      $display("FAIL reset_ready: got %0d want 1", rdy0);
    end
    @(negedge clk);
    rst = 1;
  endtask

  task automatic test_back_to_back();
    int vals[4] = '{3, 7, 15, 0};
    int s = 0;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'(vals[i]), 0, 0);
      tick();
      s += vals[i];
      n_tests++;
      if (acc0 !== 16'(s) || ct0 !== 16'(i + 1)) begin
        n_fail++;
        $display("FAIL b2b_partial%0d: got acc=%0d cnt=%0d want %0d %0d",
                 i, acc0, ct0, s, i + 1);
      end
      n_tests++;
      if (vl0 !== (i == 3)) begin
        n_fail++;
        $display("FAIL b2b_valid%0d: got %0d want %0d", i, vl0, i == 3);
      end
    end
    n_tests++;
    if (acc0 !== 25 || ov0 !== 0 || rdy0 !== 0) begin
      n_fail++;
      $display("FAIL b2b_final: got acc=%0d ovf=%0d rdy=%0d want 25 0 0",
               acc0, ov0, rdy0);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      drive(1, 4'd9, 0, 0);
      tick();
      n_tests++;
      if (vl0 !== 1 || acc0 !== 25 || ct0 !== 4 || ov0 !== 0 || rdy0 !== 0) begin
        n_fail++;
        $display("FAIL hold%0d: got v=%0d a=%0d c=%0d o=%0d r=%0d want 1 25 4 0 0",
                 i, vl0, acc0, ct0, ov0, rdy0);
      end
    end
    drive(1, 4'd9, 0, 1);
    tick();
    n_tests++;
    if (vl0 !== 0 || acc0 !== 0 || ct0 !== 0 || rdy0 !== 1) begin
      n_fail++;
      $display("FAIL hold_release: got v=%0d a=%0d c=%0d r=%0d want 0 0 0 1",
               vl0, acc0, ct0, rdy0);
    end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 4'd15, 0, 0);
      tick();
      n_tests++;
      if (acc1 !== 5'((i == 0) ? 15 : (i == 1) ? 30 : 31) ||
          ov1 !== (i >= 2)) begin
        n_fail++;
        $display("FAIL sat%0d: got acc=%0d ovf=%0d", i, acc1, ov1);
      end
    end
    drive(0, 0, 0, 0);
    tick();
    n_tests++;
    if (vl1 !== 1 || acc1 !== 31 || ov1 !== 1 || ct1 !== 4) begin
      n_fail++;
      $display("FAIL sat_hold: got v=%0d a=%0d o=%0d c=%0d want 1 31 1 4",
               vl1, acc1, ov1, ct1);
    end
  endtask

  task automatic test_clear();
    do_reset();
    repeat (2) begin
      drive(1, 4'd5, 0, 0);
      tick();
    end
    drive(1, 4'd5, 1, 0);
    #1;
    n_tests++;
    if (rdy0 !== 0) begin
      n_fail++;
      $display("FAIL clear_ready: got %0d want 0", rdy0);
    end
    tick();
    n_tests++;
    if (acc0 !== 0 || ct0 !== 0 || vl0 !== 0) begin
      n_fail++;
      $display("FAIL clear_flush: got a=%0d c=%0d v=%0d want 0 0 0",
               acc0, ct0, vl0);
    end
    drive(1, 4'd2, 0, 0);
    tick();
    n_tests++;
    if (acc0 !== 2 || ct0 !== 1 || vl0 !== 0) begin
      n_fail++;
      $display("FAIL clear_idle: got a=%0d c=%0d v=%0d want 2 1 0",
               acc0, ct0, vl0);
    end
    repeat (3) begin
      drive(1, 4'd1, 0, 0);
      tick();
    end
    drive(0, 0, 1, 0);
    tick();
    n_tests++;
    if (vl0 !== 0 || acc0 !== 0 || ct0 !== 0) begin
      n_fail++;
      $display("FAIL clear_hold: got v=%0d a=%0d c=%0d want 0 0 0",
               vl0, acc0, ct0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1, 4'd4, 0, 0);
    tick();
    drive(1, 4'd5, 0, 0);
    tick();
    in_valid = 0;
    #2;
    rst = 0;
    #1;
    n_tests++;
    if (acc0 !== 0 || ct0 !== 0 || vl0 !== 0) begin
      n_fail++;
      $display("FAIL async_rst: got a=%0d c=%0d v=%0d want 0 0 0",
               acc0, ct0, vl0);
    end
    @(negedge clk);
    rst = 1;
    drive(1, 4'd7, 0, 0);
    tick();
    n_tests++;
    if (acc0 !== 7 || ct0 !== 1) begin
      n_fail++;
      $display("FAIL rst_resume: got a=%0d c=%0d want 7 1", acc0, ct0);
    end
  endtask

  task automatic test_single();
    do_reset();
    drive(1, 4'd6, 0, 0);
    tick();
    n_tests++;
    if (vl2 !== 1 || acc2 !== 6 || ct2 !== 1 || rdy2 !== 0) begin
      n_fail++;
      $display("FAIL single: got v=%0d a=%0d c=%0d r=%0d want 1 6 1 0",
               vl2, acc2, ct2, rdy2);
    end
  endtask

  task automatic test_random();
    int msum[3];
    int mn[3];
    bit mhold[3];
    int mmax[3] = '{4, 4, 1};
    int mlim[3] = '{65535, 31, 65535};
    logic v, clr, ordy;
    logic [3:0] val;
    logic [31:0] g_acc[3];
    logic [15:0] g_ct[3];
    logic g_v[3], g_o[3], g_r[3];
    int ea;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      msum[k] = 0; mn[k] = 0; mhold[k] = 0;
    end
    for (int c = 0; c < 400; c++) begin
      v = 1'($urandom_range(0, 3) != 0);
      val = 4'($urandom_range(0, 15));
      clr = 1'($urandom_range(0, 24) == 0);
      ordy = 1'($urandom_range(0, 2) == 0);
      drive(v, val, clr, ordy);
      #1;
      g_r = '{rdy0, rdy1, rdy2};
      for (int k = 0; k < 3; k++) begin
        n_tests++;
        if (g_r[k] !== (!mhold[k] && !clr)) begin
          n_fail++;
          $display("FAIL rnd_ready u%0d c%0d: got %0d want %0d",
                   k, c, g_r[k], !mhold[k] && !clr);
        end
      end
      tick();
      for (int k = 0; k < 3; k++) begin
        if (clr || (mhold[k] && ordy)) begin
          msum[k] = 0; mn[k] = 0; mhold[k] = 0;
        end else if (!mhold[k] && v) begin
          msum[k] += int'(val);
          mn[k]++;
          if (mn[k] == mmax[k]) mhold[k] = 1;
        end
      end
      g_acc = '{32'(acc0), 32'(acc1), 32'(acc2)};
      g_ct = '{ct0, ct1, ct2};
      g_v = '{vl0, vl1, vl2};
      g_o = '{ov0, ov1, ov2};
      for (int k = 0; k < 3; k++) begin
        ea = (msum[k] > mlim[k]) ? mlim[k] : msum[k];
        n_tests++;
        if (g_acc[k] !== 32'(ea) || g_ct[k] !== 16'(mn[k]) ||
            g_v[k] !== mhold[k] || g_o[k] !== (msum[k] > mlim[k])) begin
          n_fail++;
          $display("FAIL rnd_out u%0d c%0d: got a=%0d c=%0d v=%0d o=%0d want %0d %0d %0d %0d",
                   k, c, g_acc[k], g_ct[k], g_v[k], g_o[k],
                   ea, mn[k], mhold[k], msum[k] > mlim[k]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_hold();
    test_saturate();
    test_clear();
    test_async_reset();
    test_single();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
